ifu_prefetch: RTL and testbench
===============================

Name: ifu_prefetch

Overview:
Parametrised instruction-fetch unit replacing the single-register PC update of the single-cycle core. It owns the fetch PC, issues requests to a synchronous instruction memory with 1-cycle read latency, and buffers returned instructions with their PCs in a DEPTH-entry prefetch queue. The queue feeds decode through a valid/ready handshake. Branch and jump redirects from execute flush the queue and any in-flight request.

Parameters:
XLEN, 32, PC/address width in bits
RESET_PC, 32'h0000_3000, fetch PC loaded on reset
DEPTH, 4, prefetch queue entries; power of two, at least 2

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
im_req  output  1  instruction read request this cycle
im_addr  output  XLEN  read address; equals the fetch PC
im_rdata  input  32  instruction word, valid the cycle after an accepted im_req
redirect_valid  input  1  branch/jump taken; load redirect_pc
redirect_pc  input  XLEN  redirect target
out_valid  output  1  queue head valid
out_ready  input  1  decode accepts head
out_instr  output  32  head instruction
out_pc  output  XLEN  head instruction PC
count  output  $clog2(DEPTH+1)  current queue occupancy
misalign_err  output  1  sticky; last redirect target not word-aligned

Behaviour:
- Reset (asynchronous): fetch_pc=RESET_PC, inflight=0, queue empty, count=0, out_valid=0, out_instr=0, out_pc=0, misalign_err=0, im_req=0.
- pop = out_valid & out_ready. Pop with redirect_valid in the same cycle is still a completed transfer.
- im_req = !reset & !redirect_valid & !misalign_err & ((count + inflight < DEPTH) | pop). The combinational path from out_ready to im_req is intentional; it gives 1 instr/cycle at DEPTH=2.
- On im_req at an edge: inflight<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (mod 2^XLEN; wraps silently). Otherwise inflight<=0.
- If inflight is set and no redirect occurs this cycle: push {im_rdata, inflight_pc} at the edge. Push is never blocked; the issue rule guarantees space.
- Push and pop in the same cycle: count unchanged, both take effect.
- No bypass: an instruction becomes visible on out_* the cycle after im_rdata arrives. Fetch-to-out latency is 2 cycles.
- redirect_valid at an edge:
  - queue cleared, count<=0, inflight<=0; an in-flight response arriving that cycle is discarded.
  - fetch_pc<=redirect_pc.
  - misalign_err<=(redirect_pc[1:0]!=0).
  - First out_valid after the redirect is 2 cycles later, carrying out_pc=redirect_pc.
- misalign_err set: no im_req. The queue still drains to decode. The flag clears only on a later aligned redirect or on reset.
- Empty queue: out_valid=0; out_instr/out_pc hold their last values (no requirement).
- Reset asserted mid-operation: all state returns to reset values immediately; any pending response is ignored.

Decomposition:
- Shared package (cpu_pkg): INSTR_W=32, PC_STEP=4, DEFAULT_RESET_PC=32'h0000_3000.
- One sub-module, ifu_fifo: synchronous FIFO with width and depth parameters, synchronous flush, simultaneous push/pop, and a count output. It stores {pc, instr}.
- ifu_prefetch holds the fetch PC, inflight tracking, issue logic and misalign flag.

Test Plan:
- Reset release, out_ready=1 held: im_addr 0x3000, 0x3004, 0x3008 on consecutive cycles; out_pc 0x3000 appears 2 cycles after the first req, then one per cycle; count stays at most 1.
- out_ready=0, DEPTH=4: exactly 4 requests issued; count=4; im_req=0. Raise out_ready: im_req reasserts in the same cycle as the first pop; order 0x3000.. preserved.
- Redirect to 0x3100 with queue at count=3 and a request in flight: next cycle count=0; stale word not pushed; im_addr=0x3100; out_pc=0x3100 two cycles later.
- Redirect to 0x3102: misalign_err=1, im_req stays 0. Redirect to 0x3200: misalign_err=0, fetch resumes at 0x3200.
- Redirect to 0xFFFF_FFFC with XLEN=32: the following im_addr is 0x0000_0000 (wrap).
- Assert reset while count=2 and inflight=1: out_valid=0 and count=0 immediately. After release, the first im_addr is 0x3000.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants for the core's fetch path.
package cpu_pkg;
  localparam int          INSTR_W          = 32;
  localparam int          PC_STEP          = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
endpackage

// File: rtl/ifu_fifo.sv
// Synchronous prefetch FIFO: synchronous flush, simultaneous push/pop, occupancy count.
module ifu_fifo
  import cpu_pkg::*;
#(
  parameter int W     = 64,
  parameter int DEPTH = 4,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop_ok;
  logic          push_ok;

  assign pop_ok  = pop & (count != '0);
  // A push into a full queue is only legal when the head leaves in the same cycle.
  assign push_ok = push & ((count != CW'(DEPTH)) | pop_ok);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction fetch unit: fetch PC, one outstanding memory request, prefetch queue to decode.
module ifu_prefetch
  import cpu_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC),
  parameter int              DEPTH    = 4,
  localparam int             CW       = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  output logic               im_req,
  output logic [XLEN-1:0]    im_addr,
  input  logic [INSTR_W-1:0] im_rdata,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [XLEN-1:0]    out_pc,
  output logic [CW-1:0]      count,
  output logic               misalign_err
);

  localparam int QW = XLEN + INSTR_W;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] inflight_pc;
  logic            inflight;
  logic            pop;
  logic            push;
  logic            issue;
  logic [CW:0]     occupancy;
  logic [QW-1:0]   q_dout;

  assign pop       = out_valid & out_ready;
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};

  // out_ready reaches issue combinationally so a pop frees a slot for this cycle's
  // request; that is what sustains one instruction per cycle at DEPTH=2.
  assign issue   = ~redirect_valid & ~misalign_err &
                   ((occupancy < (CW+1)'(DEPTH)) | pop);
  assign im_req  = issue & ~reset;
  assign im_addr = fetch_pc;

  // A response landing in a redirect cycle belongs to the abandoned path.
  assign push = inflight & ~redirect_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc     <= RESET_PC;
      inflight     <= 1'b0;
      inflight_pc  <= '0;
      misalign_err <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc     <= redirect_pc;
      inflight     <= 1'b0;
      misalign_err <= (redirect_pc[1:0] != 2'b00);
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + XLEN'(PC_STEP);
      end
    end
  end

  ifu_fifo #(
    .W     (QW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect_valid),
    .push  (push),
    .din   ({inflight_pc, im_rdata}),
    .pop   (pop),
    .dout  (q_dout),
    .count (count)
  );

  assign out_valid = (count != '0);
  assign out_pc    = q_dout[QW-1:INSTR_W];
  assign out_instr = q_dout[INSTR_W-1:0];

endmodule

// File: tb/tb_ifu_prefetch.sv
// Self-checking bench for ifu_prefetch: directed sequences, redirect vector table, output scoreboard.
module tb_ifu_prefetch;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic            clk = 1'b0;
  logic            reset;
  logic            im_req;
  logic [XLEN-1:0] im_addr;
  logic [31:0]     im_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic [XLEN-1:0] out_pc;
  logic [CW-1:0]   count;
  logic            misalign_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] sb_q[$];

  typedef struct {
    logic [31:0] pc;
    logic        exp_misalign;
    logic [31:0] exp_next_addr;
  } redir_vec_t;

  redir_vec_t vecs[7];

  ifu_prefetch #(.XLEN(XLEN), .RESET_PC(32'h0000_3000), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .im_req         (im_req),
    .im_addr        (im_addr),
    .im_rdata       (im_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .count          (count),
    .misalign_err   (misalign_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  // Instruction memory: 1-cycle read latency; request captured mid-cycle to avoid edge races.
  logic        req_q;
  logic [31:0] addr_q;
  always @(negedge clk) begin
    req_q  <= im_req;
    addr_q <= im_addr;
  end
  always @(posedge clk) im_rdata <= req_q ? word_of(addr_q) : 32'hDEAD_BEEF;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic sb_fill(input logic [31:0] start, input int n);
    sb_q.delete();
    for (int i = 0; i < n; i++) sb_q.push_back(start + 32'(4 * i));
  endtask

  task automatic sb_check();
    logic [31:0] pc;
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_pop", {32'h0, out_pc}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        pc = sb_q.pop_front();
        chk("sb_pc", out_pc, pc);
        chk("sb_instr", out_instr, word_of(pc));
      end
    end
  endtask

  // Inputs change at posedge+1, checks run at posedge+2, scoreboard samples at negedge.
  task automatic tick();
    @(negedge clk);
    sb_check();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;
    sb_q.delete();
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nreq;
    vecs[0] = '{32'h0000_3100, 1'b0, 32'h0000_3104};
    vecs[1] = '{32'h0000_3102, 1'b1, 32'h0000_0000};
    vecs[2] = '{32'h0000_3200, 1'b0, 32'h0000_3204};
    vecs[3] = '{32'h0000_3101, 1'b1, 32'h0000_0000};
    vecs[4] = '{32'h0000_3203, 1'b1, 32'h0000_0000};
    vecs[5] = '{32'hFFFF_FFFC, 1'b0, 32'h0000_0000};
    vecs[6] = '{32'h0000_3300, 1'b0, 32'h0000_3304};

    // Reset state
    do_reset();
    #1;
    chk("rst_im_req", im_req, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_misalign", misalign_err, 0);
    chk("rst_im_addr", im_addr, 32'h3000);

    // Streaming with decode always ready
    tick();
    sb_fill(32'h3000, 40);
    out_ready = 1'b1;
    reset     = 1'b0;
    #1;
    chk("s_req0", im_req, 1);
    chk("s_addr0", im_addr, 32'h3000);
    tick(); #1;
    chk("s_addr1", im_addr, 32'h3004);
    chk("s_valid1", out_valid, 0);
    tick(); #1;
    chk("s_addr2", im_addr, 32'h3008);
    chk("s_valid2", out_valid, 1);
    chk("s_pc2", out_pc, 32'h3000);
    for (int i = 0; i < 6; i++) begin
      chk("s_count_le1", (count <= 1), 1);
      chk("s_req", im_req, 1);
      tick(); #1;
    end

    // Fill with decode stalled, then release
    do_reset();
    sb_fill(32'h3000, 40);
    reset = 1'b0;
    #1;
    nreq = 0;
    for (int i = 0; i < 8; i++) begin
      if (im_req) nreq++;
      tick(); #1;
    end
    chk("f_req_total", nreq, 4);
    chk("f_count", count, 4);
    chk("f_req_full", im_req, 0);
    chk("f_valid", out_valid, 1);
    out_ready = 1'b1;
    #1;
    chk("f_req_on_pop", im_req, 1);
    chk("f_addr_on_pop", im_addr, 32'h3010);
    for (int i = 0; i < 8; i++) tick();

    // Redirect with count=3 and a request in flight
    do_reset();
    sb_fill(32'h3000, 8);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    #1;
    chk("r_count3", count, 3);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h3100;
    #1;
    chk("r_req_low", im_req, 0);
    tick();
    redirect_valid = 1'b0;
    sb_fill(32'h3100, 40);
    out_ready = 1'b1;
    #1;
    chk("r_count0", count, 0);
    chk("r_valid0", out_valid, 0);
    chk("r_req", im_req, 1);
    chk("r_addr", im_addr, 32'h3100);
    tick();
    tick(); #1;
    chk("r_valid", out_valid, 1);
    chk("r_pc", out_pc, 32'h3100);
    for (int i = 0; i < 3; i++) tick();

    // Redirect vector table, decode ready
    for (int v = 0; v < 7; v++) begin
      redirect_valid = 1'b1;
      redirect_pc    = vecs[v].pc;
      #1;
      chk("t_req_in_redirect", im_req, 0);
      tick();
      redirect_valid = 1'b0;
      if (vecs[v].exp_misalign) sb_q.delete();
      else sb_fill(vecs[v].pc, 40);
      #1;
      chk("t_misalign", misalign_err, vecs[v].exp_misalign);
      chk("t_req", im_req, !vecs[v].exp_misalign);
      chk("t_count0", count, 0);
      if (!vecs[v].exp_misalign) chk("t_addr", im_addr, vecs[v].pc);
      tick(); #1;
      if (!vecs[v].exp_misalign) chk("t_next_addr", im_addr, vecs[v].exp_next_addr);
      else chk("t_req_held_low", im_req, 0);
      tick(); #1;
      chk("t_valid", out_valid, !vecs[v].exp_misalign);
      if (!vecs[v].exp_misalign) chk("t_pc", out_pc, vecs[v].pc);
      tick();
      tick();
    end

    // Reset asserted mid-operation
    do_reset();
    sb_fill(32'h3000, 8);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    #1;
    chk("m_count2", count, 2);
    reset = 1'b1;
    #1;
    chk("m_valid", out_valid, 0);
    chk("m_count", count, 0);
    chk("m_req", im_req, 0);
    tick();
    sb_fill(32'h3000, 40);
    out_ready = 1'b1;
    reset     = 1'b0;
    #1;
    chk("m_req_after", im_req, 1);
    chk("m_addr_after", im_addr, 32'h3000);
    tick();
    tick(); #1;
    chk("m_valid_after", out_valid, 1);
    chk("m_pc_after", out_pc, 32'h3000);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
